// File: rtl/opmem_stream_pkg.sv
// Shared types and frame geometry for the output-memory raster streamer.
// Holds the FSM state encoding and the beat record carried through the skid buffer.
package opmem_stream_pkg;

   localparam int unsigned IMG_W      = 800;
   localparam int unsigned IMG_H      = 600;
   localparam int unsigned IMG_PIXELS = IMG_W * IMG_H;
   localparam int unsigned PIX_W      = 8;
   localparam int unsigned ADDR_W     = 19;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } stream_state_e;

   typedef struct packed {
      logic             sof;
      logic             eol;
      logic             eof;
      logic [PIX_W-1:0] data;
   } beat_t;

   // Assembles a beat from flags captured at issue time and the returned pixel.
   function automatic beat_t make_beat(input logic sof, input logic eol, input logic eof,
                                       input logic [PIX_W-1:0] data);
      beat_t b;
      b.sof  = sof;
      b.eol  = eol;
      b.eof  = eof;
      b.data = data;
      return b;
   endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry beat FIFO between the output-memory read port and the pixel stream.
// Entry 0 is always the head; the count output lets the reader gate new issues.
module pix_skid_fifo
   import opmem_stream_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  beat_t      push_beat_i,
   input  logic       pop_i,
   output beat_t      head_o,
   output logic [1:0] count_o,
   output logic       empty_o
);

   beat_t [1:0] mem_q, mem_d;
   logic  [1:0] count_q, count_d;
   logic        pop_eff;

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      // A pop against an empty buffer is ignored, so push+pop then behaves as a push.
      pop_eff = pop_i && (count_q != 2'd0);
      unique case ({push_i, pop_eff})
         2'b10: begin
            mem_d[count_q[0]] = push_beat_i;
            count_d           = count_q + 2'd1;
         end
         2'b01: begin
            mem_d[0] = mem_q[1];
            count_d  = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               mem_d[0] = push_beat_i;
            end else begin
               mem_d[0] = mem_q[1];
               mem_d[1] = push_beat_i;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q   <= '0;
         count_q <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[0];
   assign count_o = count_q;
   assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/opmem_pixel_streamer.sv
// Raster readout of the sharpened frame: sequential synchronous reads of the output
// memory, re-timed through a two-entry skid buffer into a valid/ready pixel stream.
module opmem_pixel_streamer #(
   parameter int unsigned IMG_W  = opmem_stream_pkg::IMG_W,
   parameter int unsigned IMG_H  = opmem_stream_pkg::IMG_H,
   parameter int unsigned PIX_W  = opmem_stream_pkg::PIX_W,
   parameter int unsigned ADDR_W = opmem_stream_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic [PIX_W-1:0]  px_data,
   output logic              px_valid,
   input  logic              px_ready,
   output logic              px_sof,
   output logic              px_eol,
   output logic              px_eof,
   output logic              busy,
   output logic              done
);

   import opmem_stream_pkg::*;

   localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   stream_state_e     state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic              busy_q;
   logic              done_pulse_q;

   // Read issued last cycle: its data is on rd_data now, its flags travel alongside.
   logic              pend_q;
   logic              pend_sof_q;
   logic              pend_eol_q;
   logic              pend_eof_q;

   beat_t             push_beat;
   beat_t             head_beat;
   logic  [1:0]       fifo_count;
   logic              fifo_empty;
   logic              pop;
   logic  [2:0]       slots_used;
   logic              last_col;
   logic              last_pix;

   always_comb begin
      last_col  = (col_q == COL_W'(IMG_W - 1));
      last_pix  = last_col && (row_q == ROW_W'(IMG_H - 1));
      pop       = !fifo_empty && px_ready;
      push_beat = make_beat(pend_sof_q, pend_eol_q, pend_eof_q, rd_data);
      // Slots are counted after this cycle's pop so a draining buffer refills
      // without a bubble; the pending read always has a slot reserved.
      slots_used = {1'b0, fifo_count} + {2'b00, pend_q} - {2'b00, pop};
      rd_en      = (state_q == StRun) && (slots_used < 3'd2);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
         busy_q       <= 1'b0;
         done_pulse_q <= 1'b0;
         pend_q       <= 1'b0;
         pend_sof_q   <= 1'b0;
         pend_eol_q   <= 1'b0;
         pend_eof_q   <= 1'b0;
      end else begin
         pend_q <= rd_en;
         if (rd_en) begin
            pend_sof_q <= (addr_q == '0);
            pend_eol_q <= last_col;
            pend_eof_q <= last_pix;
         end

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
                  addr_q  <= '0;
                  col_q   <= '0;
                  row_q   <= '0;
               end
            end
            StRun: begin
               if (rd_en) begin
                  addr_q <= addr_q + ADDR_W'(1);
                  if (last_col) begin
                     col_q <= '0;
                     row_q <= row_q + ROW_W'(1);
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
                  if (last_pix) begin
                     state_q <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (pop && head_beat.eof) begin
                  state_q      <= StDone;
                  busy_q       <= 1'b0;
                  done_pulse_q <= 1'b1;
               end
            end
            StDone: begin
               done_pulse_q <= 1'b0;
               state_q      <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   pix_skid_fifo u_fifo (
      .clk_i       (clk),
      .rst_ni      (reset),
      .push_i      (pend_q),
      .push_beat_i (push_beat),
      .pop_i       (pop),
      .head_o      (head_beat),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty)
   );

   assign rd_addr  = addr_q;
   assign busy     = busy_q;
   assign done     = done_pulse_q;
   assign px_valid = !fifo_empty;
   assign px_data  = head_beat.data;
   assign px_sof   = head_beat.sof;
   assign px_eol   = head_beat.eol;
   assign px_eof   = head_beat.eof;

endmodule
